// File: rtl/lsu_arbiter.sv
// -----------------------------------------------------------------------------
// lsu_arbiter
//   Shares the single load/store unit port between the CPU memory stage
//   (port A, normally high priority) and a DMA/boot-loader master (port B).
//   One access is granted per cycle. Load data is captured at the closing edge
//   of the grant cycle and returned to the winner one cycle later.
//   Forward progress: a pending DMA request refused STARVE_LIMIT cycles in a
//   row is forced to win, and a locked DMA burst is capped at BURST_MAX grants.
//
// Ports
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_cpu_* / i_dma_*               request fields (held stable until granted)
//   i_dma_lock                      DMA burst request, sampled on DMA grants
//   o_cpu_gnt / o_dma_gnt           combinational grant (at most one per cycle)
//   o_*_rsp_vld, o_*_ld_data        registered load response
//   o_lsu_*                         fields driven to the LSU
//   i_lsu_ld_data                   combinational load data from the LSU
// -----------------------------------------------------------------------------
module lsu_arbiter #(
  parameter int STARVE_LIMIT = 8,  // 1..255
  parameter int BURST_MAX    = 4   // 1..255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cpu_req,
  input  logic        i_cpu_wren,
  input  logic [2:0]  i_cpu_func3,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_st_data,
  output logic        o_cpu_gnt,
  output logic        o_cpu_rsp_vld,
  output logic [31:0] o_cpu_ld_data,
  input  logic        i_dma_req,
  input  logic        i_dma_wren,
  input  logic [2:0]  i_dma_func3,
  input  logic [31:0] i_dma_addr,
  input  logic [31:0] i_dma_st_data,
  input  logic        i_dma_lock,
  output logic        o_dma_gnt,
  output logic        o_dma_rsp_vld,
  output logic [31:0] o_dma_ld_data,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_lsu_st_data,
  output logic [2:0]  o_lsu_func3,
  output logic        o_lsu_wren,
  input  logic [31:0] i_lsu_ld_data
);

  typedef enum logic {ST_IDLE, ST_DMA_BURST} state_t;

  localparam logic [7:0] L_STARVE_LIMIT = 8'(STARVE_LIMIT);
  localparam logic [7:0] L_BURST_MAX    = 8'(BURST_MAX);
  localparam logic       L_BURST_EN     = (BURST_MAX > 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_starve_cnt, w_starve_nxt;
  logic [7:0] r_burst_cnt, w_burst_nxt;
  logic       w_cpu_gnt, w_dma_gnt;

  // Arbitration and next-state.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is
    // inferred on paths that do not assign it.
    w_cpu_gnt   = 1'b0;
    w_dma_gnt   = 1'b0;
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;

    case (r_state)
      ST_IDLE: begin
        if (i_dma_req && (!i_cpu_req || (r_starve_cnt == L_STARVE_LIMIT))) begin
          w_dma_gnt = 1'b1;
        end else if (i_cpu_req) begin
          w_cpu_gnt = 1'b1;
        end
        if (w_dma_gnt && i_dma_lock && L_BURST_EN) begin
          w_state_nxt = ST_DMA_BURST;
          w_burst_nxt = 8'd1;
        end
      end
      ST_DMA_BURST: begin
        if (i_dma_req) begin
          w_dma_gnt   = 1'b1;
          w_burst_nxt = r_burst_cnt + 8'd1;
          if (!i_dma_lock || (w_burst_nxt >= L_BURST_MAX)) begin
            w_state_nxt = ST_IDLE;
            w_burst_nxt = 8'd0;
          end
        end else begin
          // DMA dropped its request: the burst is over and the CPU may use
          // this otherwise idle slot.
          w_cpu_gnt   = i_cpu_req;
          w_state_nxt = ST_IDLE;
          w_burst_nxt = 8'd0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_burst_nxt = 8'd0;
      end
    endcase

    // Grants must vanish the moment reset asserts, not at the next edge, so
    // no store reaches the LSU while the arbiter is held in reset.
    if (!i_rst_n) begin
      w_cpu_gnt = 1'b0;
      w_dma_gnt = 1'b0;
    end
  end

  // Starvation counter: counts refused DMA cycles, saturating at the limit.
  always_comb begin
    if (!i_dma_req || w_dma_gnt) begin
      w_starve_nxt = 8'd0;
    end else if (r_starve_cnt < L_STARVE_LIMIT) begin
      w_starve_nxt = r_starve_cnt + 8'd1;
    end else begin
      w_starve_nxt = r_starve_cnt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= 8'd0;
      r_burst_cnt  <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_burst_cnt  <= w_burst_nxt;
    end
  end

  // LSU port mux; idle cycles drive a harmless word-sized load of address 0.
  always_comb begin
    o_lsu_addr    = 32'd0;
    o_lsu_st_data = 32'd0;
    o_lsu_func3   = 3'b010;
    o_lsu_wren    = 1'b0;
    if (w_dma_gnt) begin
      o_lsu_addr    = i_dma_addr;
      o_lsu_st_data = i_dma_st_data;
      o_lsu_func3   = i_dma_func3;
      o_lsu_wren    = i_dma_wren;
    end else if (w_cpu_gnt) begin
      o_lsu_addr    = i_cpu_addr;
      o_lsu_st_data = i_cpu_st_data;
      o_lsu_func3   = i_cpu_func3;
      o_lsu_wren    = i_cpu_wren;
    end
  end

  assign o_cpu_gnt = w_cpu_gnt;
  assign o_dma_gnt = w_dma_gnt;

  // Load responses: the winner's data register captures, the other holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cpu_rsp_vld <= 1'b0;
      o_cpu_ld_data <= 32'd0;
      o_dma_rsp_vld <= 1'b0;
      o_dma_ld_data <= 32'd0;
    end else begin
      o_cpu_rsp_vld <= w_cpu_gnt && !i_cpu_wren;
      o_dma_rsp_vld <= w_dma_gnt && !i_dma_wren;
      if (w_cpu_gnt && !i_cpu_wren) o_cpu_ld_data <= i_lsu_ld_data;
      if (w_dma_gnt && !i_dma_wren) o_dma_ld_data <= i_lsu_ld_data;
    end
  end

endmodule
